// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared CPU types and default sizes for the cpu, the memory
//                and the memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Default word width, memory depth and address width.
    localparam int c_DEF_N  = 16;
    localparam int c_DEF_M  = 1024;
    localparam int c_DEF_AW = 10;

    // Owner of the read word that the memory returns next cycle.
    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_IF   = 2'd1,
        RSP_DRD  = 2'd2
    } rsp_src_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/arb_prio2.sv
`default_nettype none
// ============================================================================
//  Module      : arb_prio2
//  Description : Two-requester fixed-priority grant logic. The high-priority
//                requester wins unless force_lo is set while the low-priority
//                requester is waiting.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_prio2 (
    input  logic req_hi,
    input  logic req_lo,
    input  logic force_lo,
    output logic gnt_hi,
    output logic gnt_lo
);

    // Grant decision: at most one grant, purely combinational.
    always_comb begin
        gnt_hi = req_hi && !(req_lo && force_lo);
        gnt_lo = req_lo && !gnt_hi;
    end

endmodule : arb_prio2
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one single-port synchronous-read memory between the
//                instruction-fetch path and the load/store path. Data has
//                priority; a run counter bounds fetch starvation to MAXRUN
//                consecutive data grants. Read words are routed back to the
//                requester one cycle after its grant.
//  Revision    : 1.0 - initial release
// ============================================================================
import cpu_pkg::*;

module mem_arbiter #(
    parameter int N      = c_DEF_N,
    parameter int M      = c_DEF_M,
    parameter int AW     = c_DEF_AW,
    parameter int MAXRUN = 4
) (
    input  logic          clk,
    input  logic          rst,
    // instruction-fetch port
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [N-1:0]  if_rdata,
    // load/store port
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [N-1:0]  d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [N-1:0]  d_rdata,
    // memory port
    output logic [AW-1:0] mem_addr,
    output logic [N-1:0]  mem_wdata,
    output logic          mem_we,
    input  logic [N-1:0]  mem_rdata
);

    localparam int c_RUN_W = $clog2(MAXRUN + 1);
    localparam logic [c_RUN_W-1:0] c_RUN_MAX = c_RUN_W'(MAXRUN);

    logic [c_RUN_W-1:0] r_run;
    rsp_src_t           r_rsp_src;
    rsp_src_t           w_rsp_nxt;
    logic               w_arb_dgnt;
    logic               w_arb_ignt;
    logic               w_force_if;

    // Fetch is forced through once data has won MAXRUN times in a row.
    assign w_force_if = (r_run == c_RUN_MAX);

    arb_prio2 u_arb (
        .req_hi   (d_req),
        .req_lo   (if_req),
        .force_lo (w_force_if),
        .gnt_hi   (w_arb_dgnt),
        .gnt_lo   (w_arb_ignt)
    );

    // Reset suppresses every grant so nothing reaches the memory.
    assign d_gnt  = w_arb_dgnt && !rst;
    assign if_gnt = w_arb_ignt && !rst;

    // Run counter: counts data wins while fetch waits, saturating at MAXRUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run <= '0;
        end else if (if_gnt || !if_req) begin
            r_run <= '0;
        end else if (d_gnt && (r_run != c_RUN_MAX)) begin
            r_run <= r_run + 1'b1;
        end
    end

    // Response-owner register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_src <= RSP_NONE;
        end else begin
            r_rsp_src <= w_rsp_nxt;
        end
    end

    // Next response owner: stores and idle cycles produce no response.
    always_comb begin
        w_rsp_nxt = RSP_NONE;
        if (if_gnt) begin
            w_rsp_nxt = RSP_IF;
        end else if (d_gnt && !d_we) begin
            w_rsp_nxt = RSP_DRD;
        end
    end

    // Memory drive from the winner; idle drives zeros.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_we    = d_we;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
        end
    end

    // Response routing; a response in flight when reset rises is dropped.
    always_comb begin
        if_rvalid = !rst && (r_rsp_src == RSP_IF);
        d_rvalid  = !rst && (r_rsp_src == RSP_DRD);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = d_rvalid  ? mem_rdata : '0;
    end

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed self-checking bench for mem_arbiter with a
//                behavioural synchronous-read memory and a response queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int c_N  = 16;
    localparam int c_M  = 1024;
    localparam int c_AW = 10;

    logic            clk;
    logic            rst;
    logic            if_req;
    logic [c_AW-1:0] if_addr;
    logic            if_gnt;
    logic            if_rvalid;
    logic [c_N-1:0]  if_rdata;
    logic            d_req;
    logic            d_we;
    logic [c_AW-1:0] d_addr;
    logic [c_N-1:0]  d_wdata;
    logic            d_gnt;
    logic            d_rvalid;
    logic [c_N-1:0]  d_rdata;
    logic [c_AW-1:0] mem_addr;
    logic [c_N-1:0]  mem_wdata;
    logic            mem_we;
    logic [c_N-1:0]  mem_rdata;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic           is_if;
        logic [c_N-1:0] data;
    } rsp_t;

    rsp_t           rsp_q[$];
    logic [c_N-1:0] mem     [0:c_M-1];
    logic [c_N-1:0] exp_mem [0:c_M-1];

    mem_arbiter #(
        .N(c_N), .M(c_M), .AW(c_AW), .MAXRUN(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous-read memory, write takes effect at the edge.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ":if_gnt"},    32'(if_gnt),    32'd0);
        chk({tag, ":d_gnt"},     32'(d_gnt),     32'd0);
        chk({tag, ":if_rvalid"}, 32'(if_rvalid), 32'd0);
        chk({tag, ":d_rvalid"},  32'(d_rvalid),  32'd0);
        chk({tag, ":if_rdata"},  32'(if_rdata),  32'd0);
        chk({tag, ":d_rdata"},   32'(d_rdata),   32'd0);
        chk({tag, ":mem_addr"},  32'(mem_addr),  32'd0);
        chk({tag, ":mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, ":mem_we"},    32'(mem_we),    32'd0);
    endtask

    // Compare this cycle's response outputs against the scoreboard head.
    task automatic check_rsp();
        rsp_t r;
        if (rsp_q.size() > 0) begin
            r = rsp_q.pop_front();
            if (r.is_if) begin
                chk("if_rvalid", 32'(if_rvalid), 32'd1);
                chk("if_rdata",  32'(if_rdata),  32'(r.data));
                chk("d_rvalid",  32'(d_rvalid),  32'd0);
            end else begin
                chk("d_rvalid",  32'(d_rvalid),  32'd1);
                chk("d_rdata",   32'(d_rdata),   32'(r.data));
                chk("if_rvalid", 32'(if_rvalid), 32'd0);
            end
        end else begin
            chk("idle if_rvalid", 32'(if_rvalid), 32'd0);
            chk("idle d_rvalid",  32'(d_rvalid),  32'd0);
            chk("idle if_rdata",  32'(if_rdata),  32'd0);
            chk("idle d_rdata",   32'(d_rdata),   32'd0);
        end
    endtask

    // One cycle: check responses, drive requests, check grants and memory
    // pins, record expected responses, advance the clock.
    task automatic step(input logic ir, input logic [c_AW-1:0] ia,
                        input logic dr, input logic dwe,
                        input logic [c_AW-1:0] da, input logic [c_N-1:0] dwd,
                        input logic eif, input logic ed);
        rsp_t r;
        check_rsp();
        if_req  = ir;
        if_addr = ia;
        d_req   = dr;
        d_we    = dwe;
        d_addr  = da;
        d_wdata = dwd;
        #2;
        chk("if_gnt", 32'(if_gnt), 32'(eif));
        chk("d_gnt",  32'(d_gnt),  32'(ed));
        chk("mem_we", 32'(mem_we), 32'(ed && dwe));
        if (ed) begin
            chk("mem_addr(d)", 32'(mem_addr), 32'(da));
            if (dwe) chk("mem_wdata", 32'(mem_wdata), 32'(dwd));
        end else if (eif) begin
            chk("mem_addr(if)", 32'(mem_addr), 32'(ia));
        end else begin
            chk("idle mem_addr",  32'(mem_addr),  32'd0);
            chk("idle mem_wdata", 32'(mem_wdata), 32'd0);
        end
        if (eif) begin
            r.is_if = 1'b1;
            r.data  = exp_mem[ia];
            rsp_q.push_back(r);
        end else if (ed && !dwe) begin
            r.is_if = 1'b0;
            r.data  = exp_mem[da];
            rsp_q.push_back(r);
        end else if (ed && dwe) begin
            exp_mem[da] = dwd;
        end
        tick();
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < c_M; i++) begin
            mem[i]     = '0;
            exp_mem[i] = '0;
        end
        mem[0]  = 16'h5A5A;  exp_mem[0]  = 16'h5A5A;
        mem[5]  = 16'hA123;  exp_mem[5]  = 16'hA123;
        mem[9]  = 16'h0BAD;  exp_mem[9]  = 16'h0BAD;

        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

        // Idle after reset.
        tick();
        chk_all_zero("rst1");
        tick();
        chk_all_zero("rst2");
        rst = 1'b0;
        repeat (3) idle();

        // Single fetch.
        step(1'b1, 10'd5, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        idle();

        // Store then load back to back, same address.
        step(1'b0, '0, 1'b1, 1'b1, 10'd7, 16'h00FF, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, 10'd7, '0,       1'b0, 1'b1);
        idle();

        // Starvation bound: D D D D F D D D D F.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 10'd5, 1'b1, 1'b0, 10'd7, '0, (i % 5) == 4, (i % 5) != 4);
        end
        idle();

        // Simultaneous requests: data first, held fetch next.
        step(1'b1, 10'd5, 1'b1, 1'b0, 10'd9, '0, 1'b0, 1'b1);
        step(1'b1, 10'd5, 1'b0, 1'b0, '0,    '0, 1'b1, 1'b0);
        idle();

        // Store beats a waiting fetch, then fetch reads the stored word.
        step(1'b1, 10'd12, 1'b1, 1'b1, 10'd12, 16'hBEEF, 1'b0, 1'b1);
        step(1'b1, 10'd12, 1'b0, 1'b0, '0,     '0,       1'b1, 1'b0);
        idle();

        // Reset mid-read: the load's response must be dropped.
        step(1'b0, '0, 1'b1, 1'b0, 10'd7, '0, 1'b0, 1'b1);
        rsp_q.delete();
        rst = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = 10'd3; d_wdata = 16'h1111;
        #2;
        chk_all_zero("midrst");
        tick();
        rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        #1;
        chk("post-rst d_rvalid",  32'(d_rvalid),  32'd0);
        chk("post-rst if_rvalid", 32'(if_rvalid), 32'd0);
        tick();
        idle();
        step(1'b1, 10'd3, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port, synchronous-read word memory between the CPU's instruction-fetch path and its load/store data path. Each cycle it grants at most one requester and drives the memory address, write data and write enable. It routes the read word back to the winning requester one cycle later. Data accesses have fixed priority, and a run counter bounds how long fetch can be starved.

## Interface

Parameters:
- N, 16, word width in bits
- M, 1024, memory depth in words
- AW, 10, address width; must satisfy 2^AW >= M
- MAXRUN, 4, maximum consecutive data grants while a fetch is waiting; range 1..15

Ports:
- clk  in  1  system clock; everything is on the rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  AW  fetch word address; stable while if_req=1
- if_gnt  out  1  fetch accepted this cycle (combinational)
- if_rvalid  out  1  fetch word valid this cycle
- if_rdata  out  N  fetch word
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store, 0 = load; stable while d_req=1
- d_addr  in  AW  data word address
- d_wdata  in  N  store data
- d_gnt  out  1  data access accepted this cycle (combinational)
- d_rvalid  out  1  load word valid this cycle; never pulses for stores
- d_rdata  out  N  load word
- mem_addr  out  AW  memory address, sampled by the memory on clk
- mem_wdata  out  N  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  N  memory read word; valid the cycle after its address

## Operation

- **Grant rule** (combinational on the current inputs and `run`):
  - rst=1: no grant.
  - Both requesting and run < MAXRUN: data wins.
  - Both requesting and run == MAXRUN: fetch wins.
  - Only one requesting: that requester wins.
  - Neither requesting: no grant.
- **Memory drive:**
  - Memory pins take the winner's address, write data and we.
  - Fetch grant drives mem_we=0.
  - No grant (idle): mem_addr=0, mem_wdata=0, mem_we=0.
  - mem_we=1 only in a cycle with d_gnt=1 and d_we=1.
- **run counter** (log2(MAXRUN+1) bits, reset 0), updated each cycle:
  - d_gnt=1 while if_req=1: run increments, saturating at MAXRUN.
  - if_gnt=1, or if_req=0: run clears to 0.
- **rsp_src register** (2-bit enum NONE / IF / DRD, reset NONE), records the owner of the next response:
  - if_gnt=1: next value IF.
  - d_gnt=1 with d_we=0: next value DRD.
  - Otherwise (store grant or idle): next value NONE.
- **Response outputs:**
  - if_rvalid = (rsp_src == IF), with if_rdata = mem_rdata.
  - d_rvalid = (rsp_src == DRD), with d_rdata = mem_rdata.
  - Each rdata output reads 0 when its rvalid is 0.
- **Ordering:** one access in flight, with a fully pipelined throughput of one grant per cycle. A new grant is allowed in the same cycle a response is returned.
- **Read-after-write:** a store granted in cycle t followed by a load or fetch of the same address granted in t+1 returns the stored value. No forwarding is needed, because the memory writes at the end of cycle t.
- **Illegal combinations** are not checked: requests with addr >= M, and requests dropped before grant.

## Timing

- Grant latency: 0 cycles; the grant asserts in the same cycle as the request when it wins.
- Read latency: rvalid asserts exactly 1 cycle after the grant.
- Store completion: d_gnt is the completion; no response follows.
- Reset:
  - While rst=1, all outputs are 0, including if_gnt, d_gnt and mem_we.
  - On the first cycle after reset: run=0, rsp_src=NONE, both rvalid=0.
- Reset mid-operation: a grant issued in the cycle before rst rises gets no response. rsp_src is forced to NONE by the reset edge.
- Worst-case fetch wait under continuous data requests: MAXRUN cycles.

## Structure

- Shared package cpu_pkg holds:
  - the rsp_src enum (RSP_NONE, RSP_IF, RSP_DRD);
  - the defaults for N, M and AW, used by the cpu, memory and arbiter.
- Sub-module arb_prio2 holds the combinational grant logic for two requesters. It has a force-low-priority input driven by (run == MAXRUN).
- The run counter and rsp_src register live in mem_arbiter.

## Test plan

- **Idle after reset:** hold rst=1 for 2 cycles, then release with no requests. Required: all outputs 0, and mem_we stays 0.
- **Single fetch:** memory preloaded with mem[5]=0xA123; if_req=1, if_addr=5 for one cycle. Required: if_gnt=1 in that cycle, then if_rvalid=1 with if_rdata=0xA123 in the next cycle, with d_rvalid=0.
- **Store then load, back to back:**
  - Cycle 1: store d_addr=7, d_wdata=0x00FF. Required: d_gnt=1, mem_we=1.
  - Cycle 2: load d_addr=7.
  - Cycle 3: required d_rvalid=1, d_rdata=0x00FF; no d_rvalid after the store itself.
- **Starvation bound:** MAXRUN=4; d_req held high with loads and if_req held high for 10 cycles. Required grant pattern: D D D D F D D D D F, with run returning to 0 after each F.
- **Simultaneous single-cycle requests:** both request in one cycle with run=0. Required: d_gnt=1, if_gnt=0, and fetch is granted in the next cycle if if_req is still held.
- **Reset mid-read:** load granted in cycle t, rst=1 in cycle t+1. Required: d_rvalid=0 in t+1 and t+2, and rsp_src=NONE after release.
